// File: rtl/fir_fold_mac_sched_if.sv
// Stream, coefficient-write and shared-multiplier signals of the folded FIR scheduler.
interface fir_fold_mac_sched_if #(
  parameter int NTAPS  = 8,
  parameter int DIN_W  = 16,
  parameter int COEF_W = 6,
  parameter int PROD_W = 22,
  parameter int ACC_W  = 25
);
  localparam int AW = $clog2(NTAPS);

  logic [DIN_W-1:0]  s_data;
  logic              s_valid;
  logic              s_ready;
  logic              coef_we;
  logic [AW-1:0]     coef_addr;
  logic [COEF_W-1:0] coef_wdata;
  logic [DIN_W-1:0]  mul_a;
  logic [COEF_W-1:0] mul_b;
  logic [PROD_W-1:0] mul_p;
  logic [ACC_W-1:0]  m_data;
  logic              m_valid;
  logic              m_ready;
  logic              busy;

  // scheduler side
  modport master (
    input  s_data, s_valid, coef_we, coef_addr, coef_wdata, mul_p, m_ready,
    output s_ready, mul_a, mul_b, m_data, m_valid, busy
  );

  // environment side: sample source, coefficient writer, multiplier, sink
  modport slave (
    output s_data, s_valid, coef_we, coef_addr, coef_wdata, mul_p, m_ready,
    input  s_ready, mul_a, mul_b, m_data, m_valid, busy
  );
endinterface

// File: rtl/fir_fold_mac_sched.sv
// Folded direct-form FIR scheduler: one shared multiplier, one tap per cycle,
// newest sample first, full-precision accumulate, valid/ready output.
module fir_fold_mac_sched #(
  parameter int NTAPS  = 8,
  parameter int DIN_W  = 16,
  parameter int COEF_W = 6,
  parameter int PROD_W = 22,
  parameter int ACC_W  = 25
) (
  input logic                  ap_clk,
  input logic                  ap_rst_n,
  fir_fold_mac_sched_if.master bus
);
  localparam int AW = $clog2(NTAPS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  logic [1:0]                          state_q, state_d;
  logic [AW-1:0]                       wp_q, wp_d;
  logic [AW-1:0]                       k_q, k_d;
  logic signed [ACC_W-1:0]             acc_q, acc_d;
  logic [ACC_W-1:0]                    m_data_q, m_data_d;
  logic                                m_valid_q, m_valid_d;
  logic [NTAPS-1:0][DIN_W-1:0]         x_q, x_d;
  logic [NTAPS-1:0][COEF_W-1:0]        c_q, c_d;

  // delay-line read index walks backwards from the newest sample, wrapping mod NTAPS
  logic [AW-1:0] rd_idx;
  assign rd_idx = wp_q - k_q;

  // stream flags and multiplier operands depend only on registered state
  always_comb begin
    bus.s_ready = (state_q == S_IDLE);
    bus.busy    = (state_q == S_MAC) || (state_q == S_OUT);
    bus.m_data  = m_data_q;
    bus.m_valid = m_valid_q;
    bus.mul_a   = '0;
    bus.mul_b   = '0;
    if (state_q == S_MAC) begin
      bus.mul_a = x_q[rd_idx];
      bus.mul_b = c_q[k_q];
    end
  end

  // next-state: accept sample, run NTAPS MAC cycles, hold result until taken
  always_comb begin
    state_d   = state_q;
    wp_d      = wp_q;
    k_d       = k_q;
    acc_d     = acc_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    x_d       = x_q;
    c_d       = c_q;
    case (state_q)
      S_IDLE: begin
        // a write coinciding with an accepted sample is visible to that sample's MAC pass
        if (bus.coef_we) c_d[bus.coef_addr] = bus.coef_wdata;
        if (bus.s_valid) begin
          x_d[wp_q] = bus.s_data;
          acc_d     = '0;
          k_d       = '0;
          state_d   = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_q + ACC_W'($signed(bus.mul_p));
        k_d   = k_q + AW'(1);
        if (k_q == AW'(NTAPS - 1)) begin
          m_data_d  = acc_d;
          m_valid_d = 1'b1;
          state_d   = S_OUT;
        end
      end
      S_OUT: begin
        if (bus.m_ready) begin
          m_valid_d = 1'b0;
          wp_d      = wp_q + AW'(1);
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state registers; reset also wipes delay line and coefficients
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q   <= S_IDLE;
      wp_q      <= '0;
      k_q       <= '0;
      acc_q     <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      x_q       <= '0;
      c_q       <= '0;
    end else begin
      state_q   <= state_d;
      wp_q      <= wp_d;
      k_q       <= k_d;
      acc_q     <= acc_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      x_q       <= x_d;
      c_q       <= c_d;
    end
  end
endmodule

// File: tb/tb_fir_fold_mac_sched.sv
// Directed + random bench for the folded FIR scheduler against a sum-of-products model.
module tb_fir_fold_mac_sched;
  localparam int NTAPS  = 8;
  localparam int DIN_W  = 16;
  localparam int COEF_W = 6;
  localparam int PROD_W = 22;
  localparam int ACC_W  = 25;
  localparam int AW     = $clog2(NTAPS);

  logic ap_clk = 1'b0;
  logic ap_rst_n;

  fir_fold_mac_sched_if #(.NTAPS(NTAPS), .DIN_W(DIN_W), .COEF_W(COEF_W),
                          .PROD_W(PROD_W), .ACC_W(ACC_W)) bus ();

  fir_fold_mac_sched #(.NTAPS(NTAPS), .DIN_W(DIN_W), .COEF_W(COEF_W),
                       .PROD_W(PROD_W), .ACC_W(ACC_W)) dut (
    .ap_clk  (ap_clk),
    .ap_rst_n(ap_rst_n),
    .bus     (bus)
  );

  always #5 ap_clk = ~ap_clk;

  // external combinational multiplier
  assign bus.mul_p = PROD_W'(PROD_W'($signed(bus.mul_a)) * PROD_W'($signed(bus.mul_b)));

  int checks = 0;
  int errors = 0;

  // reference: coefficient table and sample history, hist[0] newest
  int cm[NTAPS];
  int hist[NTAPS];

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NTAPS; i++) begin cm[i] = 0; hist[i] = 0; end
  endtask

  task automatic model_push(input int s, output int y);
    for (int i = NTAPS - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = s;
    y = 0;
    for (int i = 0; i < NTAPS; i++) y += cm[i] * hist[i];
  endtask

  task automatic do_reset();
    ap_rst_n = 1'b0;
    #1;
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_m_data", bus.m_data, 0);
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    model_clear();
  endtask

  // starts and ends just after a negedge with the DUT in IDLE
  task automatic write_coef(input int k, input int v);
    bus.coef_we    = 1'b1;
    bus.coef_addr  = AW'(k);
    bus.coef_wdata = COEF_W'(v);
    @(posedge ap_clk); #1;
    bus.coef_we = 1'b0;
    cm[k] = v;
    @(negedge ap_clk);
  endtask

  // one sample through the pipe; hold = cycles of back-pressure at OUT,
  // mac_we = attempt a c[0]=5 write while the MAC pass runs
  task automatic xfer(input int s, input bit we, input int wa, input int wd,
                      input int hold, input bit mac_we, output int y, output time t_acc);
    int n;
    logic [ACC_W-1:0] held;
    chk("s_ready_idle", bus.s_ready, 1);
    if (hold > 0) bus.m_ready = 1'b0;
    bus.s_data  = DIN_W'(s);
    bus.s_valid = 1'b1;
    if (we) begin
      bus.coef_we = 1'b1; bus.coef_addr = AW'(wa); bus.coef_wdata = COEF_W'(wd);
    end
    @(posedge ap_clk);
    t_acc = $time;
    #1;
    bus.coef_we = 1'b0;
    // keep valid up with junk data: must not be consumed while busy
    bus.s_data = 16'h5A5A;
    if (we) cm[wa] = wd;
    model_push(s, y);
    n = 0;
    do begin
      @(negedge ap_clk);
      n++;
      if (mac_we && n == 3) begin
        bus.coef_we = 1'b1; bus.coef_addr = '0; bus.coef_wdata = COEF_W'(5);
      end else bus.coef_we = 1'b0;
    end while (!bus.m_valid && n < 40);
    bus.coef_we = 1'b0;
    chk("latency", n, NTAPS + 1);
    chk("m_data", longint'($signed(bus.m_data)), y);
    held = bus.m_data;
    for (int i = 0; i < hold; i++) begin
      chk("bp_s_ready", bus.s_ready, 0);
      chk("bp_mul_a", bus.mul_a, 0);
      @(negedge ap_clk);
      chk("bp_m_valid", bus.m_valid, 1);
      chk("bp_m_data", bus.m_data, held);
    end
    bus.m_ready = 1'b1;
    @(negedge ap_clk);
    bus.s_valid = 1'b0;
    chk("post_m_valid", bus.m_valid, 0);
    chk("post_s_ready", bus.s_ready, 1);
    chk("post_busy", bus.busy, 0);
  endtask

  initial begin
    int y;
    int ylast;
    time t0, t1;
    bit saw_valid;
    ap_rst_n       = 1'b0;
    bus.s_data     = '0;
    bus.s_valid    = 1'b0;
    bus.coef_we    = 1'b0;
    bus.coef_addr  = '0;
    bus.coef_wdata = '0;
    bus.m_ready    = 1'b1;
    model_clear();
    repeat (3) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    chk("reset_s_ready", bus.s_ready, 1);
    chk("reset_m_valid", bus.m_valid, 0);
    chk("reset_m_data", bus.m_data, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_mul_a", bus.mul_a, 0);
    chk("reset_mul_b", bus.mul_b, 0);

    // impulse response reads the coefficients back in order
    for (int k = 0; k < NTAPS; k++) write_coef(k, k + 1);
    for (int i = 0; i < 12; i++) begin
      xfer((i == 0) ? 1 : 0, 1'b0, 0, 0, 0, 1'b0, y, t0);
      chk("impulse_const", y, (i < NTAPS) ? i + 1 : 0);
    end

    // largest-magnitude products, no wrap in the accumulator
    for (int k = 0; k < NTAPS; k++) write_coef(k, -32);
    for (int i = 0; i < NTAPS; i++) xfer(-32768, 1'b0, 0, 0, 0, 1'b0, ylast, t0);
    chk("extreme_sum", ylast, 8388608);

    // back-pressure at OUT plus a dropped coefficient write during MAC
    for (int k = 0; k < NTAPS; k++) write_coef(k, $urandom_range(63) - 32);
    xfer(12345, 1'b0, 0, 0, 20, 1'b1, y, t0);
    xfer(-777, 1'b0, 0, 0, 0, 1'b0, y, t0);

    // coefficient write together with sample acceptance, fresh delay line
    do_reset();
    xfer(3, 1'b1, 0, 5, 0, 1'b0, y, t0);
    chk("coef_same_cycle", y, 15);

    // reset in the middle of the MAC pass
    for (int k = 0; k < NTAPS; k++) write_coef(k, k + 1);
    bus.s_data = DIN_W'(1234); bus.s_valid = 1'b1;
    @(posedge ap_clk); #1;
    bus.s_valid = 1'b0;
    repeat (4) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b0;
    #1;
    chk("midmac_busy", bus.busy, 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    model_clear();
    saw_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge ap_clk);
      if (bus.m_valid) saw_valid = 1'b1;
    end
    chk("midmac_no_valid", saw_valid, 0);
    xfer(1, 1'b0, 0, 0, 0, 1'b0, y, t0);
    chk("midmac_cleared", y, 0);

    // random streaming: throughput and delay-line wrap
    for (int k = 0; k < NTAPS; k++) write_coef(k, $urandom_range(63) - 32);
    for (int i = 0; i < 20; i++) begin
      xfer($urandom_range(65535) - 32768, 1'b0, 0, 0, 0, 1'b0, y, t1);
      if (i > 0) chk("stream_period", longint'(t1 - t0), 10 * (NTAPS + 2));
      t0 = t1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
